id_stage_hz: RTL and testbench

//  Parametrised decode stage with its ID/EXE pipeline register. Sits between IF and EXE.

---
 rtl/id_stage_hz.sv | 207 ++++++++++++++++++++
 tb/tb_id_stage_hz.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_hz.sv
// Decode stage with ID/EXE pipeline register: opcode decode, regfile read with
// WB bypass, RAW hazard detection against EXE/MEM, flush-over-hazard bubbling.
module id_stage_hz #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned REG_AW    = 5,
   parameter bit          HAZARD_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instr_in,
   input  logic [DATA_W-1:0] pc_in,
   input  logic              valid_in,
   input  logic              flush_in,
   input  logic              wb_en_in,
   input  logic [REG_AW-1:0] wb_dest_in,
   input  logic [DATA_W-1:0] wb_data_in,
   input  logic              exe_wb_en,
   input  logic [REG_AW-1:0] exe_dest,
   input  logic              mem_wb_en,
   input  logic [REG_AW-1:0] mem_dest,
   output logic              hazard_out,
   output logic              valid_out,
   output logic              wb_en_out,
   output logic              mem_r_out,
   output logic              mem_w_out,
   output logic [1:0]        br_type_out,
   output logic [3:0]        exe_cmd_out,
   output logic [DATA_W-1:0] val1_out,
   output logic [DATA_W-1:0] val2_out,
   output logic [DATA_W-1:0] st_val_out,
   output logic [REG_AW-1:0] dest_out,
   output logic [DATA_W-1:0] pc_out
);

   localparam int unsigned NREG = 2 ** REG_AW;

   typedef enum logic [5:0] {
      OP_ADD  = 6'b000001, OP_SUB  = 6'b000011, OP_AND  = 6'b000101,
      OP_OR   = 6'b000110, OP_NOR  = 6'b000111, OP_XOR  = 6'b001000,
      OP_SLA  = 6'b001001, OP_SLL  = 6'b001010, OP_SRA  = 6'b001011,
      OP_SRL  = 6'b001100, OP_ADDI = 6'b100000, OP_SUBI = 6'b100001,
      OP_LD   = 6'b100100, OP_ST   = 6'b100101, OP_BEZ  = 6'b101000,
      OP_BNE  = 6'b101001, OP_JMP  = 6'b101010
   } opcode_e;

   typedef enum logic [1:0] {BR_NONE = 2'b00, BR_BEZ = 2'b01, BR_BNE = 2'b10, BR_JMP = 2'b11} br_e;

   logic [5:0]         op;
   logic [REG_AW-1:0]  rs, rt, rd;
   logic signed [15:0] imm;
   logic [DATA_W-1:0]  imm_ext;

   assign op      = instr_in[31:26];
   assign rs      = instr_in[21 +: REG_AW];
   assign rt      = instr_in[16 +: REG_AW];
   assign rd      = instr_in[11 +: REG_AW];
   assign imm     = instr_in[15:0];
   assign imm_ext = DATA_W'(imm);

   logic       dec_wb, dec_mr, dec_mw, dec_imm, use_rs, use_rt, dec_alu;
   logic [1:0] dec_br;
   logic [3:0] dec_cmd;

   always_comb begin
      dec_wb  = 1'b0;
      dec_mr  = 1'b0;
      dec_mw  = 1'b0;
      dec_imm = 1'b0;
      use_rs  = 1'b0;
      use_rt  = 1'b0;
      dec_alu = 1'b0;
      dec_br  = BR_NONE;
      dec_cmd = '0;
      case (op)
         OP_ADD:         begin dec_alu = 1'b1; dec_cmd = 4'b0000; end
         OP_SUB:         begin dec_alu = 1'b1; dec_cmd = 4'b0010; end
         OP_AND:         begin dec_alu = 1'b1; dec_cmd = 4'b0100; end
         OP_OR:          begin dec_alu = 1'b1; dec_cmd = 4'b0101; end
         OP_NOR:         begin dec_alu = 1'b1; dec_cmd = 4'b0110; end
         OP_XOR:         begin dec_alu = 1'b1; dec_cmd = 4'b0111; end
         OP_SLA, OP_SLL: begin dec_alu = 1'b1; dec_cmd = 4'b1000; end
         OP_SRA:         begin dec_alu = 1'b1; dec_cmd = 4'b1001; end
         OP_SRL:         begin dec_alu = 1'b1; dec_cmd = 4'b1010; end
         OP_ADDI: begin dec_wb = 1'b1; dec_imm = 1'b1; use_rs = 1'b1; end
         OP_SUBI: begin dec_wb = 1'b1; dec_imm = 1'b1; use_rs = 1'b1; dec_cmd = 4'b0010; end
         OP_LD:   begin dec_wb = 1'b1; dec_mr = 1'b1; dec_imm = 1'b1; use_rs = 1'b1; end
         OP_ST:   begin dec_mw = 1'b1; dec_imm = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
         OP_BEZ:  begin dec_br = BR_BEZ; dec_imm = 1'b1; use_rs = 1'b1; end
         OP_BNE:  begin dec_br = BR_BNE; dec_imm = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
         OP_JMP:  begin dec_br = BR_JMP; dec_imm = 1'b1; end
         default: ;
      endcase
      if (dec_alu) begin
         dec_wb = 1'b1;
         use_rs = 1'b1;
         use_rt = 1'b1;
      end
   end

   // Register file; entry 0 is never written and never read.
   logic [DATA_W-1:0] rf_q [NREG];
   logic              wb_hit;
   logic [DATA_W-1:0] rs_val, rt_val;

   assign wb_hit = wb_en_in && (wb_dest_in != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (wb_hit) begin
         rf_q[wb_dest_in] <= wb_data_in;
      end
   end

   always_comb begin
      rs_val = rf_q[rs];
      rt_val = rf_q[rt];
      if (wb_hit && wb_dest_in == rs) rs_val = wb_data_in;
      if (wb_hit && wb_dest_in == rt) rt_val = wb_data_in;
      if (rs == '0) rs_val = '0;
      if (rt == '0) rt_val = '0;
   end

   function automatic logic src_busy(input logic [REG_AW-1:0] r);
      return (r != '0) && ((exe_wb_en && r == exe_dest) || (mem_wb_en && r == mem_dest));
   endfunction

   assign hazard_out = HAZARD_EN && valid_in && !flush_in &&
                       ((use_rs && src_busy(rs)) || (use_rt && src_busy(rt)));

   logic              valid_q, valid_d, wb_q, wb_d, mr_q, mr_d, mw_q, mw_d;
   logic [1:0]        br_q, br_d;
   logic [3:0]        cmd_q, cmd_d;
   logic [DATA_W-1:0] val1_q, val1_d, val2_q, val2_d, st_q, st_d, pc_q, pc_d;
   logic [REG_AW-1:0] dest_q, dest_d;

   // Defaults form the bubble; only a clean (unflushed, unstalled) cycle loads.
   always_comb begin
      valid_d = 1'b0;
      wb_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      br_d    = '0;
      cmd_d   = '0;
      val1_d  = '0;
      val2_d  = '0;
      st_d    = '0;
      pc_d    = '0;
      dest_d  = '0;
      if (!flush_in && !hazard_out) begin
         valid_d = valid_in;
         val1_d  = rs_val;
         st_d    = rt_val;
         val2_d  = dec_imm ? imm_ext : rt_val;
         dest_d  = dec_imm ? rt : rd;
         pc_d    = pc_in;
         if (valid_in) begin
            wb_d  = dec_wb;
            mr_d  = dec_mr;
            mw_d  = dec_mw;
            br_d  = dec_br;
            cmd_d = dec_cmd;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         wb_q    <= 1'b0;
         mr_q    <= 1'b0;
         mw_q    <= 1'b0;
         br_q    <= '0;
         cmd_q   <= '0;
         val1_q  <= '0;
         val2_q  <= '0;
         st_q    <= '0;
         pc_q    <= '0;
         dest_q  <= '0;
      end else begin
         valid_q <= valid_d;
         wb_q    <= wb_d;
         mr_q    <= mr_d;
         mw_q    <= mw_d;
         br_q    <= br_d;
         cmd_q   <= cmd_d;
         val1_q  <= val1_d;
         val2_q  <= val2_d;
         st_q    <= st_d;
         pc_q    <= pc_d;
         dest_q  <= dest_d;
      end
   end

   assign valid_out   = valid_q;
   assign wb_en_out   = wb_q;
   assign mem_r_out   = mr_q;
   assign mem_w_out   = mw_q;
   assign br_type_out = br_q;
   assign exe_cmd_out = cmd_q;
   assign val1_out    = val1_q;
   assign val2_out    = val2_q;
   assign st_val_out  = st_q;
   assign dest_out    = dest_q;
   assign pc_out      = pc_q;

endmodule

// File: tb/tb_id_stage_hz.sv
// Randomised scoreboard bench for id_stage_hz against a spec-level model,
// plus a small DATA_W=16 / REG_AW=3 instance exercised with directed steps.
module tb_id_stage_hz;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] instr_in = '0, pc_in = '0, wb_data_in = '0;
   logic        valid_in = 0, flush_in = 0, wb_en_in = 0, exe_wb_en = 0, mem_wb_en = 0;
   logic [4:0]  wb_dest_in = '0, exe_dest = '0, mem_dest = '0;
   logic        hazard_out, valid_out, wb_en_out, mem_r_out, mem_w_out;
   logic [1:0]  br_type_out;
   logic [3:0]  exe_cmd_out;
   logic [31:0] val1_out, val2_out, st_val_out, pc_out;
   logic [4:0]  dest_out;

   id_stage_hz dut (
      .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .valid_in(valid_in),
      .flush_in(flush_in), .wb_en_in(wb_en_in), .wb_dest_in(wb_dest_in), .wb_data_in(wb_data_in),
      .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
      .hazard_out(hazard_out), .valid_out(valid_out), .wb_en_out(wb_en_out),
      .mem_r_out(mem_r_out), .mem_w_out(mem_w_out), .br_type_out(br_type_out),
      .exe_cmd_out(exe_cmd_out), .val1_out(val1_out), .val2_out(val2_out),
      .st_val_out(st_val_out), .dest_out(dest_out), .pc_out(pc_out));

   logic [31:0] instr_s = '0;
   logic [15:0] pc_s = '0, wb_data_s = '0;
   logic        valid_s = 0, wb_en_s = 0;
   logic [2:0]  wb_dest_s = '0;
   logic        hz_s, vo_s, wbo_s, mr_s, mw_s;
   logic [1:0]  br_s;
   logic [3:0]  cmd_s;
   logic [15:0] v1_s, v2_s, st_s, pco_s;
   logic [2:0]  dest_s;

   id_stage_hz #(.DATA_W(16), .REG_AW(3), .HAZARD_EN(1'b1)) dut16 (
      .clk(clk), .rst(rst), .instr_in(instr_s), .pc_in(pc_s), .valid_in(valid_s),
      .flush_in(1'b0), .wb_en_in(wb_en_s), .wb_dest_in(wb_dest_s), .wb_data_in(wb_data_s),
      .exe_wb_en(1'b0), .exe_dest(3'd0), .mem_wb_en(1'b0), .mem_dest(3'd0),
      .hazard_out(hz_s), .valid_out(vo_s), .wb_en_out(wbo_s), .mem_r_out(mr_s),
      .mem_w_out(mw_s), .br_type_out(br_s), .exe_cmd_out(cmd_s), .val1_out(v1_s),
      .val2_out(v2_s), .st_val_out(st_s), .dest_out(dest_s), .pc_out(pco_s));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic hz, v, wb, mr, mw;
      logic [1:0] br;
      logic [3:0] cmd;
      logic [31:0] v1, v2, st, pc;
      logic [4:0] dest;
   } exp_t;

   typedef struct packed {
      logic wb, mr, mw, imm, urs, urt;
      logic [1:0] br;
      logic [3:0] cmd;
   } dec_t;

   exp_t        sb[$];
   logic [31:0] mrf [32];

   function automatic dec_t mdecode(input logic [5:0] op);
      dec_t d = '0;
      case (op)
         6'd1:  d = '{1, 0, 0, 0, 1, 1, 2'd0, 4'b0000};
         6'd3:  d = '{1, 0, 0, 0, 1, 1, 2'd0, 4'b0010};
         6'd5:  d = '{1, 0, 0, 0, 1, 1, 2'd0, 4'b0100};
         6'd6:  d = '{1, 0, 0, 0, 1, 1, 2'd0, 4'b0101};
         6'd7:  d = '{1, 0, 0, 0, 1, 1, 2'd0, 4'b0110};
         6'd8:  d = '{1, 0, 0, 0, 1, 1, 2'd0, 4'b0111};
         6'd9, 6'd10: d = '{1, 0, 0, 0, 1, 1, 2'd0, 4'b1000};
         6'd11: d = '{1, 0, 0, 0, 1, 1, 2'd0, 4'b1001};
         6'd12: d = '{1, 0, 0, 0, 1, 1, 2'd0, 4'b1010};
         6'd32: d = '{1, 0, 0, 1, 1, 0, 2'd0, 4'b0000};
         6'd33: d = '{1, 0, 0, 1, 1, 0, 2'd0, 4'b0010};
         6'd36: d = '{1, 1, 0, 1, 1, 0, 2'd0, 4'b0000};
         6'd37: d = '{0, 0, 1, 1, 1, 1, 2'd0, 4'b0000};
         6'd40: d = '{0, 0, 0, 1, 1, 0, 2'd1, 4'b0000};
         6'd41: d = '{0, 0, 0, 1, 1, 1, 2'd2, 4'b0000};
         6'd42: d = '{0, 0, 0, 1, 0, 0, 2'd3, 4'b0000};
         default: d = '0;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] mread(input int r, input bit we, input int wd, input logic [31:0] wdat);
      if (r == 0) return 32'd0;
      if (we && wd != 0 && wd == r) return wdat;
      return mrf[r];
   endfunction

   function automatic bit busy(input int r, input bit ee, input int ed, input bit me, input int md);
      return r != 0 && ((ee && r == ed) || (me && r == md));
   endfunction

   function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input logic [15:0] imm);
      return {6'(op), 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] enc_r(input int op, input int rs, input int rt, input int rd);
      return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input bit v, input bit fl,
                        input bit we, input int wd, input logic [31:0] wdat,
                        input bit ee, input int ed, input bit me, input int md);
      exp_t e;
      dec_t d;
      int   rs, rt, rd;
      @(negedge clk);
      instr_in = ins; pc_in = pc; valid_in = v; flush_in = fl;
      wb_en_in = we; wb_dest_in = 5'(wd); wb_data_in = wdat;
      exe_wb_en = ee; exe_dest = 5'(ed); mem_wb_en = me; mem_dest = 5'(md);
      d  = mdecode(ins[31:26]);
      rs = int'(ins[25:21]);
      rt = int'(ins[20:16]);
      rd = int'(ins[15:11]);
      e  = '0;
      e.hz = v && !fl && ((d.urs && busy(rs, ee, ed, me, md)) || (d.urt && busy(rt, ee, ed, me, md)));
      if (!fl && !e.hz) begin
         e.v    = v;
         e.v1   = mread(rs, we, wd, wdat);
         e.st   = mread(rt, we, wd, wdat);
         e.v2   = d.imm ? {{16{ins[15]}}, ins[15:0]} : e.st;
         e.dest = d.imm ? 5'(rt) : 5'(rd);
         e.pc   = pc;
         if (v) begin
            e.wb = d.wb; e.mr = d.mr; e.mw = d.mw; e.br = d.br; e.cmd = d.cmd;
         end
      end
      sb.push_back(e);
      if (we && wd != 0) mrf[wd] = wdat;
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("hazard_out", 32'(hazard_out), 32'(e.hz));
            chk("valid_out", 32'(valid_out), 32'(e.v));
            chk("wb_en_out", 32'(wb_en_out), 32'(e.wb));
            chk("mem_r_out", 32'(mem_r_out), 32'(e.mr));
            chk("mem_w_out", 32'(mem_w_out), 32'(e.mw));
            chk("br_type_out", 32'(br_type_out), 32'(e.br));
            chk("exe_cmd_out", 32'(exe_cmd_out), 32'(e.cmd));
            chk("val1_out", val1_out, e.v1);
            chk("val2_out", val2_out, e.v2);
            chk("st_val_out", st_val_out, e.st);
            chk("dest_out", 32'(dest_out), 32'(e.dest));
            chk("pc_out", pc_out, e.pc);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   int ops[17] = '{1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42};

   initial begin
      for (int i = 0; i < 32; i++) mrf[i] = '0;
      #2;
      chk("rst valid_out", 32'(valid_out), 32'd0);
      chk("rst wb_en_out", 32'(wb_en_out), 32'd0);
      chk("rst val1_out", val1_out, 32'd0);
      chk("rst pc_out", pc_out, 32'd0);
      chk("rst hazard_out", 32'(hazard_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // R1 = 10, then ADDI r2,r1,-4
      drive(32'd0, 32'h0, 0, 0, 1, 1, 32'd10, 0, 0, 0, 0);
      drive(enc_i(32, 1, 2, 16'hFFFC), 32'h100, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("addi val1", val1_out, 32'd10);
      chk("addi val2", val2_out, 32'hFFFF_FFFC);
      chk("addi dest", 32'(dest_out), 32'd2);
      chk("addi wb_en", 32'(wb_en_out), 32'd1);
      // bypass r3<=0x55 while decoding ADD r4,r3,r3
      drive(enc_r(1, 3, 3, 4), 32'h104, 1, 0, 1, 3, 32'h55, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("bypass val1", val1_out, 32'h55);
      chk("bypass val2", val2_out, 32'h55);
      // write to r0 is dropped
      drive(enc_r(1, 0, 0, 5), 32'h108, 1, 0, 1, 0, 32'hDEAD, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("r0 val1", val1_out, 32'd0);
      // load-use: LD r5 in EXE, SUB r6,r5,r7 in ID
      drive(enc_r(3, 5, 7, 6), 32'h10C, 1, 0, 0, 0, 0, 1, 5, 0, 0);
      @(posedge clk); #1;
      chk("hazard raised", 32'(hazard_out), 32'd1);
      chk("hazard bubble", 32'(valid_out), 32'd0);
      drive(enc_i(42, 5, 0, 16'h0010), 32'h110, 1, 0, 0, 0, 0, 1, 5, 0, 0);
      @(posedge clk); #1;
      chk("jmp no hazard", 32'(hazard_out), 32'd0);
      chk("jmp br_type", 32'(br_type_out), 32'd3);
      drive(enc_r(3, 5, 7, 6), 32'h114, 1, 1, 0, 0, 0, 1, 5, 0, 0);
      @(posedge clk); #1;
      chk("flush hazard_out", 32'(hazard_out), 32'd0);
      chk("flush valid_out", 32'(valid_out), 32'd0);
      drive(enc_r(1, 1, 1, 8), 32'h118, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("invalid wb_en", 32'(wb_en_out), 32'd0);

      for (int n = 0; n < 400; n++) begin
         int op;
         logic [31:0] ins;
         op = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63)) : ops[$urandom_range(0, 16)];
         ins = {6'(op), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
         drive(ins, $urandom, ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
               bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
               ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)));
      end

      // mid-stream reset between edges
      drive(enc_i(32, 0, 9, 16'h1234), 32'hABC0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("midrst valid_out", 32'(valid_out), 32'd0);
      chk("midrst wb_en_out", 32'(wb_en_out), 32'd0);
      chk("midrst val2_out", val2_out, 32'd0);
      chk("midrst dest_out", 32'(dest_out), 32'd0);
      chk("midrst pc_out", pc_out, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 32; i++) mrf[i] = '0;
      for (int r = 1; r < 32; r++)
         drive(enc_r(1, r, r, 1), 32'(r), 1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      valid_in = 0;
      @(posedge clk); #2;

      // narrow configuration
      @(negedge clk);
      instr_s = enc_i(32, 0, 1, 16'h8001); pc_s = 16'h0042; valid_s = 1;
      @(posedge clk); #1;
      chk("w16 addi val2", 32'(v2_s), 32'h8001);
      chk("w16 addi dest", 32'(dest_s), 32'd1);
      chk("w16 addi val1", 32'(v1_s), 32'd0);
      @(negedge clk);
      instr_s = '0; valid_s = 0; wb_en_s = 1; wb_dest_s = 3'd7; wb_data_s = 16'h1234;
      @(negedge clk);
      wb_en_s = 0; instr_s = enc_r(1, 7, 6, 5); valid_s = 1;
      @(posedge clk); #1;
      chk("w16 r7 val1", 32'(v1_s), 32'h1234);
      chk("w16 r6 val2", 32'(v2_s), 32'd0);
      chk("w16 dest", 32'(dest_s), 32'd5);

      chk("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
